// File: rtl/game_turn_sequencer_if.sv
// ---------------------------------------------------------------------------
// game_turn_sequencer_if
// Purpose : request/acknowledge link between the turn sequencer and the
//           multi-cycle AI move engine.
// Signals :
//   ai_req    sequencer -> engine  level request, held until ai_ack
//   ai_board  sequencer -> engine  18-bit board snapshot, stable while ai_req=1
//   ai_ack    engine -> sequencer  one-cycle pulse, ai_pos valid in that cycle
//   ai_pos    engine -> sequencer  chosen cell index
// Handshake: ai_req rises with a board snapshot and stays high (snapshot
//   frozen) until the engine pulses ai_ack for exactly one cycle; the
//   sequencer samples ai_pos on that edge and drops ai_req at the same edge.
//   An ai_ack while ai_req is low carries no meaning and is ignored.
// Modports: master = sequencer side, slave = engine side.
// ---------------------------------------------------------------------------
interface game_turn_sequencer_if;
  logic        ai_req;
  logic [17:0] ai_board;
  logic        ai_ack;
  logic [3:0]  ai_pos;

  modport master (output ai_req, output ai_board, input ai_ack, input ai_pos);
  modport slave  (input ai_req, input ai_board, output ai_ack, output ai_pos);
endinterface

// File: rtl/game_turn_sequencer.sv
// ---------------------------------------------------------------------------
// game_turn_sequencer
// Purpose : tic-tac-toe turn sequencer. Owns the board register and result
//           LEDs, accepts player moves, hands the board to the AI engine,
//           writes both moves and evaluates win/draw after each one.
// Ports   :
//   clk, rst_n   clock, asynchronous active-low reset
//   new_game     one-cycle synchronous clear of the game (highest priority)
//   move_stb     one-cycle player move request, move_pos sampled with it
//   ai           AI engine link (game_turn_sequencer_if.master)
//   board        cell i = board[2i+1:2i], 00 empty
//   result       00 in play, 01 player won, 10 AI won, 11 draw
//   busy         high in every state except WAIT_P
//   illegal      one-cycle pulse after a rejected player move
//   led          {draw, AI won, player won}, follows the latched result
//   state_dbg    current FSM state encoding
// Config  : define AI_TIMEOUT_EN to add an AI watchdog of TIMEOUT_CYCLES
//           clocks; on expiry the AI move falls back to the lowest empty cell.
// ---------------------------------------------------------------------------
module game_turn_sequencer #(
  parameter logic [1:0]  PLAYER_CODE    = 2'b01,
  parameter logic [1:0]  AI_CODE        = 2'b10,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         new_game,
  input  logic                         move_stb,
  input  logic [3:0]                   move_pos,
  game_turn_sequencer_if.master        ai,
  output logic [17:0]                  board,
  output logic [1:0]                   result,
  output logic                         busy,
  output logic                         illegal,
  output logic [2:0]                   led,
  output logic [2:0]                   state_dbg
);

  typedef enum logic [2:0] {WAIT_P, CHK_P, AI_REQ, AI_WR, CHK_A, OVER} state_e;

  // The eight winning lines as cell-index triples.
  localparam int LINE_A [8] = '{0, 3, 6, 0, 1, 2, 0, 2};
  localparam int LINE_B [8] = '{1, 4, 7, 3, 4, 5, 4, 4};
  localparam int LINE_C [8] = '{2, 5, 8, 6, 7, 8, 8, 6};

  state_e      state_q, state_d;
  logic [17:0] board_q, board_d;
  logic [17:0] ai_board_q, ai_board_d;
  logic [1:0]  result_q, result_d;
  logic        ai_req_q, ai_req_d;
  logic        illegal_q, illegal_d;
  logic [3:0]  ai_pos_q, ai_pos_d;

  logic [1:0]  win_code;
  logic        board_full;
  logic [3:0]  first_empty;
  logic [1:0]  eval_result;
  logic        ai_timeout;

  // Cell read/write by a runtime index; indices above 8 read as empty and
  // write nothing, so callers must range-check first.
  function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] idx);
    logic [1:0] v;
    v = 2'b00;
    for (int i = 0; i < 9; i++) if (idx == 4'(i)) v = b[2*i +: 2];
    return v;
  endfunction

  function automatic logic [17:0] set_cell(input logic [17:0] b, input logic [3:0] idx,
                                           input logic [1:0] code);
    logic [17:0] r;
    r = b;
    for (int i = 0; i < 9; i++) if (idx == 4'(i)) r[2*i +: 2] = code;
    return r;
  endfunction

  // Board evaluation; a line win takes precedence over a full board.
  always_comb begin
    win_code    = 2'b00;
    board_full  = 1'b1;
    first_empty = 4'hF;
    for (int l = 0; l < 8; l++) begin
      if (board_q[2*LINE_A[l] +: 2] != 2'b00 &&
          board_q[2*LINE_A[l] +: 2] == board_q[2*LINE_B[l] +: 2] &&
          board_q[2*LINE_A[l] +: 2] == board_q[2*LINE_C[l] +: 2])
        win_code = board_q[2*LINE_A[l] +: 2];
    end
    // Descending scan so the last hit is the lowest empty index.
    for (int i = 8; i >= 0; i--) begin
      if (board_q[2*i +: 2] == 2'b00) begin
        board_full  = 1'b0;
        first_empty = 4'(i);
      end
    end
    if (win_code == PLAYER_CODE)  eval_result = 2'b01;
    else if (win_code != 2'b00)   eval_result = 2'b10;
    else if (board_full)          eval_result = 2'b11;
    else                          eval_result = 2'b00;
  end

`ifdef AI_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;

  assign ai_timeout = (state_q == AI_REQ) && (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  // Zero outside AI_REQ, so every entry starts a fresh count.
  assign to_cnt_d   = (state_q == AI_REQ && state_d == AI_REQ) ? to_cnt_q + 1'b1 : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) to_cnt_q <= '0;
    else        to_cnt_q <= to_cnt_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign ai_timeout         = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    board_d    = board_q;
    ai_board_d = ai_board_q;
    result_d   = result_q;
    ai_req_d   = ai_req_q;
    ai_pos_d   = ai_pos_q;
    illegal_d  = 1'b0;
    if (new_game) begin
      state_d    = WAIT_P;
      board_d    = '0;
      ai_board_d = '0;
      result_d   = 2'b00;
      ai_req_d   = 1'b0;
      ai_pos_d   = '0;
    end else begin
      case (state_q)
        WAIT_P: begin
          if (move_stb) begin
            if (move_pos > 4'd8 || cell_at(board_q, move_pos) != 2'b00) begin
              illegal_d = 1'b1;
            end else begin
              board_d = set_cell(board_q, move_pos, PLAYER_CODE);
              state_d = CHK_P;
            end
          end
        end
        CHK_P, CHK_A: begin
          if (eval_result != 2'b00) begin
            result_d = eval_result;
            state_d  = OVER;
          end else if (state_q == CHK_P) begin
            ai_board_d = board_q;
            ai_req_d   = 1'b1;
            state_d    = AI_REQ;
          end else begin
            state_d = WAIT_P;
          end
        end
        AI_REQ: begin
          if (ai.ai_ack) begin
            ai_pos_d = ai.ai_pos;
            ai_req_d = 1'b0;
            state_d  = AI_WR;
          end else if (ai_timeout) begin
            ai_pos_d = 4'hF;  // out of range forces the fallback cell
            ai_req_d = 1'b0;
            state_d  = AI_WR;
          end
        end
        AI_WR: begin
          if (ai_pos_q > 4'd8 || cell_at(board_q, ai_pos_q) != 2'b00)
            board_d = set_cell(board_q, first_empty, AI_CODE);
          else
            board_d = set_cell(board_q, ai_pos_q, AI_CODE);
          state_d = CHK_A;
        end
        OVER:    state_d = OVER;
        default: state_d = WAIT_P;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WAIT_P;
      board_q    <= '0;
      ai_board_q <= '0;
      result_q   <= 2'b00;
      ai_req_q   <= 1'b0;
      ai_pos_q   <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      board_q    <= board_d;
      ai_board_q <= ai_board_d;
      result_q   <= result_d;
      ai_req_q   <= ai_req_d;
      ai_pos_q   <= ai_pos_d;
      illegal_q  <= illegal_d;
    end
  end

  assign ai.ai_req   = ai_req_q;
  assign ai.ai_board = ai_board_q;
  assign board       = board_q;
  assign result      = result_q;
  assign illegal     = illegal_q;
  assign busy        = (state_q != WAIT_P);
  assign led         = {result_q == 2'b11, result_q == 2'b10, result_q == 2'b01};
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_game_turn_sequencer.sv
// ---------------------------------------------------------------------------
// tb_game_turn_sequencer
// Bench for game_turn_sequencer: plays complete games against a scripted AI
// engine, tracking a reference board and pushing expected boards into a
// queue that is drained when the sequencer presents them.
// ---------------------------------------------------------------------------
module tb_game_turn_sequencer;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        new_game = 1'b0;
  logic        move_stb = 1'b0;
  logic [3:0]  move_pos = 4'd0;
  logic [17:0] board;
  logic [1:0]  result;
  logic        busy;
  logic        illegal;
  logic [2:0]  led;
  logic [2:0]  state_dbg;

  game_turn_sequencer_if ai_if ();

  game_turn_sequencer #(
    .PLAYER_CODE   (2'b01),
    .AI_CODE       (2'b10),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .new_game (new_game),
    .move_stb (move_stb),
    .move_pos (move_pos),
    .ai       (ai_if),
    .board    (board),
    .result   (result),
    .busy     (busy),
    .illegal  (illegal),
    .led      (led),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [17:0] exp_q[$];
  logic [17:0] m_board = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [1:0] m_cell(input logic [17:0] b, input int i);
    return b[2*i +: 2];
  endfunction

  function automatic logic [17:0] m_put(input logic [17:0] b, input int i, input logic [1:0] c);
    logic [17:0] r;
    r = b;
    r[2*i +: 2] = c;
    return r;
  endfunction

  function automatic logic [1:0] m_result(input logic [17:0] b);
    int ln [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                      '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    logic full;
    for (int l = 0; l < 8; l++) begin
      if (m_cell(b, ln[l][0]) != 2'b00 && m_cell(b, ln[l][0]) == m_cell(b, ln[l][1]) &&
          m_cell(b, ln[l][1]) == m_cell(b, ln[l][2]))
        return (m_cell(b, ln[l][0]) == 2'b01) ? 2'b01 : 2'b10;
    end
    full = 1'b1;
    for (int i = 0; i < 9; i++) if (m_cell(b, i) == 2'b00) full = 1'b0;
    return full ? 2'b11 : 2'b00;
  endfunction

  function automatic int m_fallback(input logic [17:0] b);
    for (int i = 0; i < 9; i++) if (m_cell(b, i) == 2'b00) return i;
    return 0;
  endfunction

  function automatic logic [2:0] m_led(input logic [1:0] r);
    return {r == 2'b11, r == 2'b10, r == 2'b01};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_game();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    m_board  = '0;
    check("ng_board", 32'(board), 0);
    check("ng_result", 32'(result), 0);
    check("ng_busy", 32'(busy), 0);
  endtask

  // Legal player move followed by the evaluation cycle.
  task automatic player_move(input int pos);
    logic [1:0] r;
    m_board = m_put(m_board, pos, 2'b01);
    r = m_result(m_board);
    if (r == 2'b00) exp_q.push_back(m_board);
    move_pos = 4'(pos);
    move_stb = 1'b1;
    tick();
    move_stb = 1'b0;
    check("board_after_move", 32'(board), 32'(m_board));
    check("ai_req_lat1", 32'(ai_if.ai_req), 0);
    tick();
    check("result_after_move", 32'(result), 32'(r));
    check("led_after_move", 32'(led), 32'(m_led(r)));
    if (r == 2'b00) begin
      check("ai_req_lat2", 32'(ai_if.ai_req), 1);
      check("ai_board", 32'(ai_if.ai_board), 32'(exp_q.pop_front()));
    end else begin
      check("no_ai_req", 32'(ai_if.ai_req), 0);
    end
  endtask

  // Engine acknowledges with pos; busy is expected to fall 2 cycles later.
  task automatic engine_ack(input int pos);
    int tgt;
    logic [1:0] r;
    tgt = pos;
    if (pos > 8) tgt = m_fallback(m_board);
    else if (m_cell(m_board, pos) != 2'b00) tgt = m_fallback(m_board);
    m_board = m_put(m_board, tgt, 2'b10);
    r = m_result(m_board);
    exp_q.push_back(m_board);
    ai_if.ai_pos = 4'(pos);
    ai_if.ai_ack = 1'b1;
    tick();
    ai_if.ai_ack = 1'b0;
    check("ai_req_drop", 32'(ai_if.ai_req), 0);
    tick();
    check("board_after_ai", 32'(board), 32'(exp_q.pop_front()));
    check("busy_chk_a", 32'(busy), 1);
    tick();
    check("result_after_ai", 32'(result), 32'(r));
    check("led_after_ai", 32'(led), 32'(m_led(r)));
    check("busy_after_ai", 32'(busy), 32'(r != 2'b00));
  endtask

  task automatic illegal_move(input logic [3:0] pos);
    move_pos = pos;
    move_stb = 1'b1;
    tick();
    move_stb = 1'b0;
    check("illegal_pulse", 32'(illegal), 1);
    check("illegal_board", 32'(board), 32'(m_board));
    check("illegal_busy", 32'(busy), 0);
    tick();
    check("illegal_clear", 32'(illegal), 0);
    check("illegal_no_req", 32'(ai_if.ai_req), 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    ai_if.ai_ack = 1'b0;
    ai_if.ai_pos = 4'd0;
    tick();
    tick();
    check("rst_board", 32'(board), 0);
    check("rst_result", 32'(result), 0);
    check("rst_led", 32'(led), 0);
    check("rst_ai_req", 32'(ai_if.ai_req), 0);
    check("rst_ai_board", 32'(ai_if.ai_board), 0);
    check("rst_illegal", 32'(illegal), 0);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    tick();
    check("rst_state", 32'(state_dbg), 0);

    // Basic turn: player 4, AI 0.
    player_move(4);
    check("board_00100", 32'(board), 32'(18'h00100));
    engine_ack(0);
    check("board_00102", 32'(board), 32'(18'h00102));

    // Rejected moves and stray ack in WAIT_P.
    illegal_move(4'd4);
    illegal_move(4'd9);
    ai_if.ai_pos = 4'd5;
    ai_if.ai_ack = 1'b1;
    tick();
    ai_if.ai_ack = 1'b0;
    tick();
    check("stray_ack_board", 32'(board), 32'(m_board));
    check("stray_ack_busy", 32'(busy), 0);

    // Player wins on row 0.
    start_game();
    player_move(0);
    engine_ack(3);
    player_move(1);
    engine_ack(4);
    player_move(2);
    check("pwin_result", 32'(result), 1);
    check("pwin_led", 32'(led), 32'(3'b001));
    move_pos = 4'd5;
    move_stb = 1'b1;
    ai_if.ai_ack = 1'b1;
    tick();
    move_stb = 1'b0;
    ai_if.ai_ack = 1'b0;
    tick();
    check("over_move_ignored", 32'(board), 32'(m_board));
    check("over_no_illegal", 32'(illegal), 0);
    check("over_busy", 32'(busy), 1);

    // Occupied AI pick falls back to the lowest empty cell.
    start_game();
    player_move(4);
    engine_ack(4);
    check("fallback_cell0", 32'(board), 32'(18'h00102));

    // Draw game with an occupied pick and an out-of-range pick.
    start_game();
    player_move(0);
    engine_ack(0);
    player_move(2);
    engine_ack(4);
    player_move(3);
    engine_ack(15);
    player_move(7);
    engine_ack(6);
    player_move(8);
    check("draw_result", 32'(result), 3);
    check("draw_led", 32'(led), 32'(3'b100));

    // AI wins on row 1.
    start_game();
    player_move(0);
    engine_ack(3);
    player_move(1);
    engine_ack(4);
    player_move(8);
    engine_ack(5);
    check("awin_led", 32'(led), 32'(3'b010));

    // new_game and move_stb together: clear wins, move dropped.
    new_game = 1'b1;
    move_stb = 1'b1;
    move_pos = 4'd2;
    tick();
    new_game = 1'b0;
    move_stb = 1'b0;
    m_board  = '0;
    check("ng_prio_board", 32'(board), 0);
    check("ng_prio_busy", 32'(busy), 0);
    check("ng_prio_led", 32'(led), 0);
    tick();
    check("ng_prio_board2", 32'(board), 0);

    // new_game during AI_REQ drops the request; late ack ignored.
    player_move(6);
    start_game();
    check("ng_drop_req", 32'(ai_if.ai_req), 0);
    ai_if.ai_pos = 4'd1;
    ai_if.ai_ack = 1'b1;
    tick();
    ai_if.ai_ack = 1'b0;
    tick();
    check("late_ack_board", 32'(board), 0);
    check("late_ack_busy", 32'(busy), 0);

    // Asynchronous reset while waiting for the engine.
    player_move(4);
    #3 rst_n = 1'b0;
    #1;
    check("arst_ai_req", 32'(ai_if.ai_req), 0);
    check("arst_board", 32'(board), 0);
    check("arst_ai_board", 32'(ai_if.ai_board), 0);
    check("arst_result", 32'(result), 0);
    tick();
    rst_n   = 1'b1;
    m_board = '0;
    tick();
    check("arst_busy", 32'(busy), 0);
    check("arst_state", 32'(state_dbg), 0);

`ifdef AI_TIMEOUT_EN
    // Engine never answers: watchdog forces the fallback cell.
    begin
      int n;
      player_move(4);
      n = 0;
      while (ai_if.ai_req && n < 40) begin
        tick();
        n++;
      end
      check("timeout_cycles", 32'(n), 16);
      m_board = m_put(m_board, m_fallback(m_board), 2'b10);
      tick();
      check("timeout_board", 32'(board), 32'(m_board));
      tick();
      check("timeout_busy", 32'(busy), 0);
    end
`endif

    check("exp_q_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
